dsr_bitslip_ctrl: RTL and testbench
===================================

// Module: dsr_bitslip_ctrl
// PURPOSE
//  Sits directly downstream of the DSR alignment FSM and consumes its one-cycle BIT_SLIP_EVN/ODD,
//  DSR_RST and STRT_PIPE pulses. It converts them into deserializer-safe controls:
//  - stretched SERDES reset
//  - rate-limited per-lane BITSLIP pulses, with a request queue
//  - modulo slip counters
//  - a pipeline enable raised only after the last slip has settled.
// PARAMETERS
//  SLIP_GAP     4  minimum cycles between BITSLIP pulses on one lane, counted edge to edge (legal 1..15)
//  DSR_RST_LEN  4  cycles SERDES_RST stays high after the last DSR_RST cycle (legal 1..15)
//  WIDTH        8  deserialization ratio; modulus of the slip counters (legal 2..16)
//  MAX_PEND     3  per-lane pending slip request capacity (legal 1..3)
// PORTS
//  CLK           in   1  sole clock, rising edge
//  RST_N         in   1  reset, synchronous, active-low
//  DSR_RST       in   1  deserializer reset request from align FSM (level, may last many cycles)
//  BIT_SLIP_EVN  in   1  one-cycle slip request, even lane
//  BIT_SLIP_ODD  in   1  one-cycle slip request, odd lane
//  STRT_PIPE     in   1  one-cycle pipeline start request
//  ALIGNED       in   1  align FSM locked; gates PIPE_EN
//  SERDES_RST    out  1  stretched reset to ISERDES pair
//  SLIP_EVN      out  1  BITSLIP pulse, even ISERDES
//  SLIP_ODD      out  1  BITSLIP pulse, odd ISERDES
//  SLIP_CNT_EVN  out  4  slips applied to even lane, mod WIDTH
//  SLIP_CNT_ODD  out  4  slips applied to odd lane, mod WIDTH
//  PIPE_EN       out  1  downstream data pipeline enable
//  BUSY          out  1  SERDES_RST | any pending | any gap counter nonzero
//  OVFL          out  1  sticky: a slip request was dropped because its queue was full
// BEHAVIOUR
//  Reset: RST_N=0 at a rising edge clears every register. All outputs 0; FSM enters IDLE.
//  Outputs: all outputs are registered, except BUSY, which is combinational from registers.
//  FSM states:
//   IDLE    -> RSTH when DSR_RST=1.
//   RSTH    SERDES_RST=1, pending/gap/slip counts/PIPE_EN/arm cleared. Stays while DSR_RST=1.
//           On DSR_RST=0, load rcnt=DSR_RST_LEN-1 and go to RSTWAIT.
//   RSTWAIT SERDES_RST=1. Decrement rcnt; at rcnt==0 go to RUN. DSR_RST=1 here -> back to RSTH.
//   RUN     slip engines and PIPE_EN logic active. DSR_RST=1 -> RSTH; takes effect next cycle.
//  Slip requests and pulses in IDLE/RSTH/RSTWAIT: requests are ignored, not queued. No OVFL, no SLIP_*.
//  Per-lane slip engine (RUN only; both lanes identical and independent):
//   Request at edge N, issuing lane (pend>0 and gap==0): SLIP_x=1 for cycle N+1 only; pend--;
//     gap=SLIP_GAP-1; slip_cnt=(slip_cnt+1)==WIDTH ? 0 : slip_cnt+1.
//   Request, idle lane (pend==0, gap==0): pend 0->1 at N; SLIP_x high in cycle N+2.
//   Request and issue in the same cycle: pend unchanged.
//   Request with pend==MAX_PEND and no issue that cycle: request dropped, OVFL<=1 (sticky until reset).
//   gap decrements by 1 per cycle while nonzero. With SLIP_GAP=1, back-to-back pulses are legal.
//   Even and odd lanes may pulse in the same cycle.
//  PIPE_EN:
//   STRT_PIPE in RUN sets arm.
//   PIPE_EN<=1 when arm & ALIGNED & both pend==0 & both gap==0; arm then clears.
//   PIPE_EN holds 1 until DSR_RST, RST_N, or ALIGNED=0 for 1 cycle; any of these clears it next edge.
//   STRT_PIPE while PIPE_EN=1: no effect.
//  The align FSM output sequence is a legal input stream:
//   DSR_RST train, several slip pairs, BIT_SLIP_ODD only, STRT_PIPE, ALIGNED.
// TESTING
//  1 Reset: RST_N=0 two cycles with random inputs -> all outputs 0; OVFL 0; FSM IDLE.
//  2 DSR_RST high 5 cycles, then low -> SERDES_RST high for exactly 5+4 cycles, then RUN; BUSY mirrors it.
//  3 RUN, BIT_SLIP_EVN and BIT_SLIP_ODD pulse together at cycle 0 ->
//      SLIP_EVN and SLIP_ODD high in cycle 2 only; both SLIP_CNT_* become 1.
//  4 RUN, 3 BIT_SLIP_ODD pulses on consecutive cycles ->
//      SLIP_ODD pulses at cycles 2,6,10 (SLIP_GAP=4); SLIP_CNT_ODD=3; OVFL=0.
//    Stretch: 5 pulses with MAX_PEND=3 -> OVFL=1.
//  5 Slip-counter wrap: 8 total even slips -> SLIP_CNT_EVN returns to 0 (WIDTH=8).
//  6 STRT_PIPE while 1 slip pending, ALIGNED=1 -> PIPE_EN rises 1 cycle after gap expires.
//    DSR_RST mid-RUN with 2 slips queued -> queue flushed, no further SLIP_*, PIPE_EN=0, counts 0.

Source files
------------

// File: rtl/dsr_bitslip_ctrl.sv
// dsr_bitslip_ctrl: turns align-FSM pulses into stretched SERDES reset, rate-limited queued BITSLIP pulses, slip counters and a settled pipeline enable
module dsr_bitslip_ctrl #(
  parameter int SLIP_GAP    = 4,
  parameter int DSR_RST_LEN = 4,
  parameter int WIDTH       = 8,
  parameter int MAX_PEND    = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       dsr_rst_i,
  input  logic       bit_slip_evn_i,
  input  logic       bit_slip_odd_i,
  input  logic       strt_pipe_i,
  input  logic       aligned_i,
  output logic       serdes_rst_o,
  output logic       slip_evn_o,
  output logic       slip_odd_o,
  output logic [3:0] slip_cnt_evn_o,
  output logic [3:0] slip_cnt_odd_o,
  output logic       pipe_en_o,
  output logic       busy_o,
  output logic       ovfl_o
);
  typedef enum logic [1:0] {IDLE, RSTH, RSTWAIT, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic serdes_rst_q, pipe_en_q, pipe_en_d, arm_q, arm_d, ovfl_q, run_en, quiet, fire;
  logic [1:0] req, slip_q, drop;
  logic [1:0] pend_q [2];
  logic [3:0] gap_q [2];
  logic [3:0] cnt_q [2];
  always_comb begin
    state_d = state_q;
    rcnt_d = rcnt_q;
    case (state_q)
      IDLE: state_d = dsr_rst_i ? RSTH : IDLE;
      RSTH: if (!dsr_rst_i) begin
        state_d = RSTWAIT;
        rcnt_d = 4'(DSR_RST_LEN - 1);
      end
      RSTWAIT: if (dsr_rst_i) state_d = RSTH;
        else if (rcnt_q == 4'd0) state_d = RUN;
        else rcnt_d = rcnt_q - 4'd1;
      RUN: state_d = dsr_rst_i ? RSTH : RUN;
      default: state_d = IDLE;
    endcase
  end
  // a DSR_RST seen in RUN already freezes and flushes the engines at this edge
  assign run_en = (state_q == RUN) && !dsr_rst_i;
  assign req = {bit_slip_odd_i, bit_slip_evn_i};
  for (genvar i = 0; i < 2; i++) begin : g_lane
    logic issue;
    logic [1:0] pend_d;
    logic [3:0] gap_d, cnt_d;
    assign issue = run_en && pend_q[i] != 2'd0 && gap_q[i] == 4'd0;
    // a full queue still accepts a request in the cycle it issues
    assign drop[i] = run_en && req[i] && !issue && pend_q[i] == 2'(MAX_PEND);
    always_comb begin
      pend_d = pend_q[i] + 2'(run_en && req[i] && !drop[i]) - 2'(issue);
      gap_d = issue ? 4'(SLIP_GAP - 1) : gap_q[i] - 4'(gap_q[i] != 4'd0);
      cnt_d = !issue ? cnt_q[i] : (cnt_q[i] == 4'(WIDTH - 1)) ? 4'd0 : cnt_q[i] + 4'd1;
    end
    always_ff @(posedge clk_i) begin
      if (!rst_n_i || !run_en) begin
        pend_q[i] <= '0;
        gap_q[i] <= '0;
        cnt_q[i] <= '0;
        slip_q[i] <= 1'b0;
      end else begin
        pend_q[i] <= pend_d;
        gap_q[i] <= gap_d;
        cnt_q[i] <= cnt_d;
        slip_q[i] <= issue;
      end
    end
  end
  assign quiet = pend_q[0] == 2'd0 && pend_q[1] == 2'd0 && gap_q[0] == 4'd0 && gap_q[1] == 4'd0;
  assign fire = arm_q && aligned_i && quiet && !pipe_en_q;
  always_comb begin
    pipe_en_d = run_en && (pipe_en_q ? aligned_i : fire);
    arm_d = run_en && !fire && (arm_q || (strt_pipe_i && !pipe_en_q));
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rcnt_q <= '0;
      serdes_rst_q <= 1'b0;
      pipe_en_q <= 1'b0;
      arm_q <= 1'b0;
      ovfl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q <= rcnt_d;
      serdes_rst_q <= state_d == RSTH || state_d == RSTWAIT;
      pipe_en_q <= pipe_en_d;
      arm_q <= arm_d;
      ovfl_q <= ovfl_q || (|drop);
    end
  end
  assign serdes_rst_o = serdes_rst_q;
  assign slip_evn_o = slip_q[0];
  assign slip_odd_o = slip_q[1];
  assign slip_cnt_evn_o = cnt_q[0];
  assign slip_cnt_odd_o = cnt_q[1];
  assign pipe_en_o = pipe_en_q;
  assign ovfl_o = ovfl_q;
  assign busy_o = serdes_rst_q || pend_q[0] != 2'd0 || pend_q[1] != 2'd0 || gap_q[0] != 4'd0 || gap_q[1] != 4'd0;
endmodule

// File: tb/tb_dsr_bitslip_ctrl.sv
// tb_dsr_bitslip_ctrl: directed and random stimulus checked against a timestamp-based reference model
module tb_dsr_bitslip_ctrl;
  localparam int G = 4, L = 4, W = 8, MP = 3;
  logic clk = 0, rst_n, dsr, evn, odd, strt, al;
  logic serdes, s_evn, s_odd, pipe, busy, ovfl;
  logic [3:0] c_evn, c_odd;
  int n_cmp = 0, n_bad = 0, now = 0, last_dsr = 0, scount;
  int pend [2], last_iss [2], cnt [2];
  bit m_slip [2];
  bit seen = 0, m_ovfl = 0, m_pipe = 0, arm = 0;
  always #5 clk = ~clk;
  dsr_bitslip_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .dsr_rst_i(dsr), .bit_slip_evn_i(evn), .bit_slip_odd_i(odd),
    .strt_pipe_i(strt), .aligned_i(al), .serdes_rst_o(serdes), .slip_evn_o(s_evn), .slip_odd_o(s_odd),
    .slip_cnt_evn_o(c_evn), .slip_cnt_odd_o(c_odd), .pipe_en_o(pipe), .busy_o(busy), .ovfl_o(ovfl)
  );
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s at t=%0d observed=%0h expected=%0h", tag, now, obs, exp);
    end
  endtask
  task automatic model(input bit rn, d, e, o, s, a);
    bit run, quiet;
    bit rq [2];
    rq[0] = e;
    rq[1] = o;
    run = rn && seen && (now - 1 - last_dsr >= L + 1) && !d;
    quiet = 1;
    for (int k = 0; k < 2; k++) if (pend[k] != 0 || now - last_iss[k] < G) quiet = 0;
    if (!run) begin
      m_pipe = 0;
      arm = 0;
    end else if (m_pipe) m_pipe = a;
    else if (arm && a && quiet) begin
      m_pipe = 1;
      arm = 0;
    end else if (s) arm = 1;
    for (int k = 0; k < 2; k++) begin
      m_slip[k] = 0;
      if (!run) begin
        pend[k] = 0;
        last_iss[k] = -100;
        cnt[k] = 0;
      end else begin
        if (pend[k] > 0 && now - last_iss[k] >= G) begin
          m_slip[k] = 1;
          pend[k]--;
          last_iss[k] = now;
          cnt[k] = (cnt[k] + 1) % W;
        end
        if (rq[k]) begin
          if (pend[k] < MP) pend[k]++;
          else m_ovfl = 1;
        end
      end
    end
    if (!rn) begin
      seen = 0;
      m_ovfl = 0;
    end else if (d) begin
      seen = 1;
      last_dsr = now;
    end
  endtask
  task automatic step(input bit rn, d, e, o, s, a);
    bit m_serdes, m_busy;
    rst_n = rn; dsr = d; evn = e; odd = o; strt = s; al = a;
    @(posedge clk);
    now++;
    model(rn, d, e, o, s, a);
    #1;
    m_serdes = seen && (now - last_dsr <= L);
    m_busy = m_serdes;
    for (int k = 0; k < 2; k++) if (pend[k] != 0 || now - last_iss[k] < G - 1) m_busy = 1;
    chk("serdes_rst", 4'(serdes), 4'(m_serdes));
    chk("slip_evn", 4'(s_evn), 4'(m_slip[0]));
    chk("slip_odd", 4'(s_odd), 4'(m_slip[1]));
    chk("slip_cnt_evn", c_evn, 4'(cnt[0]));
    chk("slip_cnt_odd", c_odd, 4'(cnt[1]));
    chk("pipe_en", 4'(pipe), 4'(m_pipe));
    chk("busy", 4'(busy), 4'(m_busy));
    chk("ovfl", 4'(ovfl), 4'(m_ovfl));
  endtask
  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, a);
  endtask
  initial begin
    int hold;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0;
      last_iss[k] = -100;
      cnt[k] = 0;
    end
    for (int i = 0; i < 2; i++) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("reset_serdes", 4'(serdes), 4'd0);
    chk("reset_ovfl", 4'(ovfl), 4'd0);
    scount = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, 0, 0);
      scount += int'(serdes);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 0, 0);
      scount += int'(serdes);
    end
    chk("serdes_len", 4'(scount), 4'd9);
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("pair_pulse", {2'b0, s_evn, s_odd}, 4'b0011);
    idle(6, 0);
    chk("pair_cnt", {c_evn[1:0], c_odd[1:0]}, 4'b0101);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
    idle(12, 0);
    chk("odd_cnt3", c_odd, 4'd4);
    chk("odd_no_ovfl", 4'(ovfl), 4'd0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 0);
    idle(20, 0);
    chk("odd_ovfl", 4'(ovfl), 4'd1);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 1, 0, 0, 0);
      idle(5, 0);
    end
    chk("evn_wrap", c_evn, 4'd0);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1, 1);
    idle(10, 1);
    chk("pipe_up", 4'(pipe), 4'd1);
    step(1, 0, 0, 0, 1, 0);
    idle(2, 1);
    chk("pipe_drop", 4'(pipe), 4'd0);
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    idle(8, 1);
    chk("flush_cnt", {c_evn[1:0], c_odd[1:0]}, 4'd0);
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0 && $urandom_range(0, 60) == 0) hold = $urandom_range(1, 6);
      step($urandom_range(0, 300) != 0, hold != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 15) != 0);
      if (hold != 0) hold--;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
